// File: rtl/branch_predictor.sv
// Branch predictor: 2-bit counter BHT plus tagged BTB for fetch, and branch resolution/training from execute.
// Latency: prediction is combinational from pc_f; training is visible one cycle after the update edge.
// Backpressure: none; one lookup and one update are accepted every cycle.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_f,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic             upd_is_branch,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]            ctr        [ENTRIES];
    logic [ENTRIES-1:0]    valid;
    logic [TAG_W-1:0]      btb_tag    [ENTRIES];
    logic [31:0]           btb_target [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]      f_tag;
    logic [TAG_W-1:0]      u_tag;
    logic                  f_hit;
    logic                  train;
    logic                  invalidate;

    assign f_idx = pc_f[INDEX_BITS+1:2];
    assign f_tag = pc_f[31:INDEX_BITS+2];
    assign u_idx = upd_pc[INDEX_BITS+1:2];
    assign u_tag = upd_pc[31:INDEX_BITS+2];

    // Only conditional branches train; a non-branch that was predicted taken
    // means an aliased BTB entry, which is dropped if its tag matches.
    assign train      = upd_valid && upd_is_branch;
    assign invalidate = upd_valid && !upd_is_branch && upd_pred_taken
                        && (btb_tag[u_idx] == u_tag);

    // Fetch lookup; masked during reset so outputs show the reset state immediately.
    always_comb begin
        f_hit       = !reset && valid[f_idx] && (btb_tag[f_idx] == f_tag);
        pred_taken  = f_hit && ctr[f_idx][1];
        pred_target = pred_taken ? btb_target[f_idx] : pc_f + 32'd4;
    end

    // Resolution check against the prediction carried down the pipe.
    always_comb begin
        mispredict = 1'b0;
        if (upd_valid) begin
            if (upd_is_branch) begin
                mispredict = (upd_taken != upd_pred_taken)
                             || (upd_taken && (upd_pred_target != upd_target));
            end else begin
                mispredict = upd_pred_taken;
            end
        end
        redirect_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + 32'd4;
    end

    // Direction counters and BTB valid bits; reset wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
            valid <= '0;
        end else begin
            if (train) begin
                if (upd_taken) begin
                    if (ctr[u_idx] != 2'b11) begin
                        ctr[u_idx] <= ctr[u_idx] + 2'd1;
                    end
                    valid[u_idx] <= 1'b1;
                end else if (ctr[u_idx] != 2'b00) begin
                    ctr[u_idx] <= ctr[u_idx] - 2'd1;
                end
            end
            if (invalidate) begin
                valid[u_idx] <= 1'b0;
            end
        end
    end

    // BTB tag/target payload; taken branches overwrite whatever aliased there.
    always_ff @(posedge clk) begin
        if (!reset && train && upd_taken) begin
            btb_tag[u_idx]    <= u_tag;
            btb_target[u_idx] <= upd_target;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (train && (branch_cnt != CNT_MAX)) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (mispredict && (mispred_cnt != CNT_MAX)) begin
                mispred_cnt <= mispred_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, resolution, training, aliasing, reset and counter saturation.
// Latency: checks combinational outputs #1 after driving, registered effects #1 after the next rising edge.
// Backpressure: not applicable; the design accepts every cycle.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic        upd_is_branch;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispred_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.INDEX_BITS(4), .CNT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_f            (pc_f),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_is_branch   (upd_is_branch),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic v, input logic br, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
        upd_valid       = v;
        upd_is_branch   = br;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tg;
        upd_pred_taken  = pt;
        upd_pred_target = ptg;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        pc_f = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, "_target"}, pred_target, tg);
    endtask

    task automatic cnts(input string tag, input logic [3:0] b, input logic [3:0] m);
        chk({tag, "_branch_cnt"}, {28'd0, branch_cnt}, {28'd0, b});
        chk({tag, "_mispred_cnt"}, {28'd0, mispred_cnt}, {28'd0, m});
    endtask

    task automatic res(input string tag, input logic mp, input logic [31:0] rd);
        chk({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, mp});
        chk({tag, "_redirect"}, redirect_pc, rd);
    endtask

    initial begin
        // Reset defaults
        reset = 1'b1;
        pc_f  = 32'h40;
        idle();
        tick();
        look("rst_during", 32'h40, 1'b0, 32'h44);
        tick();
        reset = 1'b0;
        look("rst_after", 32'h40, 1'b0, 32'h44);
        cnts("rst", 4'd0, 4'd0);

        // First taken training, same-cycle lookup sees pre-update state
        upd(1'b1, 1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h44);
        res("first", 1'b1, 32'h10);
        look("same_cycle", 32'h40, 1'b0, 32'h44);
        tick();
        idle();
        cnts("first", 4'd1, 4'd1);
        look("first_next", 32'h40, 1'b1, 32'h10);

        // Two correct taken predictions: ctr 10 -> 11 -> 11
        upd(1'b1, 1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 32'h10);
        res("taken2", 1'b0, 32'h10);
        tick();
        upd(1'b1, 1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 32'h10);
        res("taken3", 1'b0, 32'h10);
        tick();
        idle();
        cnts("taken3", 4'd3, 4'd1);

        // Hysteresis: first not-taken leaves ctr at 10, still predicts taken
        upd(1'b1, 1'b1, 32'h40, 1'b0, 32'h10, 1'b1, 32'h10);
        res("nt1", 1'b1, 32'h44);
        tick();
        idle();
        look("nt1_next", 32'h40, 1'b1, 32'h10);
        upd(1'b1, 1'b1, 32'h40, 1'b0, 32'h10, 1'b1, 32'h10);
        res("nt2", 1'b1, 32'h44);
        tick();
        idle();
        look("nt2_next", 32'h40, 1'b0, 32'h44);
        cnts("nt2", 4'd5, 4'd3);

        // Retrain taken (01 -> 10), then alias: 0x00 shares the index, different tag
        upd(1'b1, 1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h44);
        tick();
        idle();
        look("alias_own", 32'h40, 1'b1, 32'h10);
        look("alias_other", 32'h00, 1'b0, 32'h04);

        // Invalid update and non-branch predicted not-taken change nothing
        upd(1'b0, 1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h44);
        res("novalid", 1'b0, 32'h10);
        upd(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        res("nonbr_ok", 1'b0, 32'h44);
        tick();
        idle();
        cnts("quiet", 4'd6, 4'd4);
        look("quiet_next", 32'h40, 1'b1, 32'h10);

        // Non-branch falsely predicted taken: flush and drop the BTB entry
        upd(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h10);
        res("nonbr_bad", 1'b1, 32'h44);
        tick();
        idle();
        look("nonbr_next", 32'h40, 1'b0, 32'h44);
        cnts("nonbr", 4'd6, 4'd5);

        // Wrong predicted target on a correctly predicted taken branch
        upd(1'b1, 1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 32'h30);
        res("bad_tgt", 1'b1, 32'h10);
        tick();
        idle();
        look("bad_tgt_next", 32'h40, 1'b1, 32'h10);
        cnts("bad_tgt", 4'd7, 4'd6);

        // Reset with a live update: the update is dropped and state is cleared
        reset = 1'b1;
        upd(1'b1, 1'b1, 32'h40, 1'b1, 32'h50, 1'b0, 32'h44);
        look("mid_rst_during", 32'h40, 1'b0, 32'h44);
        tick();
        reset = 1'b0;
        idle();
        look("mid_rst_after", 32'h40, 1'b0, 32'h44);
        cnts("mid_rst", 4'd0, 4'd0);

        // Saturation of the 4-bit statistics counters
        for (int i = 0; i < 17; i++) begin
            upd(1'b1, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
            tick();
            if (i == 14) begin
                cnts("sat15", 4'hF, 4'hF);
            end
        end
        idle();
        cnts("sat17", 4'hF, 4'hF);
        tick();
        cnts("sat_hold", 4'hF, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to execute-stage branch resolution. Predicts direction and target for the fetch PC.
- Uses a direct-mapped table of 2-bit saturating counters (BHT) and a tagged branch target buffer (BTB).
- Consumes the resolved outcome from execute: compares it against the prediction carried down the pipe, raises mispredict/redirect, and trains the tables.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- INDEX_BITS, 4, log2 of table entries. Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_f  in  32  fetch-stage PC to predict.
- pred_taken  out  1  predicted taken for pc_f (combinational lookup).
- pred_target  out  32  predicted next PC for pc_f.
- upd_valid  in  1  execute-stage instruction valid this cycle.
- upd_is_branch  in  1  instruction is a conditional branch.
- upd_pc  in  32  PC of the execute-stage instruction.
- upd_taken  in  1  resolved branch decision from execute.
- upd_target  in  32  resolved branch target (PC + B-immediate).
- upd_pred_taken  in  1  prediction made at fetch, carried with the instruction.
- upd_pred_target  in  32  predicted target carried with the instruction.
- mispredict  out  1  flush request (combinational from upd_* inputs).
- redirect_pc  out  32  correct next PC when mispredict=1.
- branch_cnt  out  CNT_W  resolved conditional branches.
- mispred_cnt  out  CNT_W  mispredictions.

Behaviour:
- **Reset.** Every counter is set to 2'b01 (weakly not-taken). All BTB valid bits are cleared. branch_cnt = mispred_cnt = 0. Reset overrides a same-cycle update, and a reset mid-training discards all learned state.
- **Lookup (combinational from registered state).**
  - hit = valid[idx] && tag[idx] == pc_f tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : pc_f + 4 (32-bit wrap).
  - During reset both outputs reflect the reset state.
- **Mispredict (combinational), only when upd_valid=1.**
  - Branch case (upd_is_branch=1): mispredict = (upd_taken != upd_pred_taken) || (upd_taken && upd_pred_target != upd_target).
  - Non-branch case (upd_is_branch=0): mispredict = upd_pred_taken (aliasing false hit).
  - redirect_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + 4.
  - When mispredict=0, redirect_pc is don't-care but driven with the same formula.
  - upd_valid=0: mispredict=0 and no state change.
- **Training at the clock edge, when upd_valid && upd_is_branch.**
  - Taken: ctr[i] increments, saturating at 2'b11. BTB entry i is written with valid=1, tag of upd_pc, target = upd_target (replaces any aliased entry).
  - Not taken: ctr[i] decrements, saturating at 2'b00. The BTB entry is left unchanged.
- **Non-branch with upd_pred_taken=1.** If the BTB tag at i matches upd_pc, clear valid[i]. Counters are unchanged.
- **Same-cycle lookup and update of the same index.** Lookup returns the pre-update value; the new value is visible the next cycle.
- **Statistics.**
  - branch_cnt += 1 on each valid branch update.
  - mispred_cnt += 1 on each cycle with mispredict=1, including the non-branch case.
  - Both saturate at all-ones; no wrap.
- **Latency.** Prediction has zero cycles of latency from pc_f. Training becomes visible one cycle after the update edge.

Test Plan:
- **Reset defaults.** Assert reset 2 cycles, pc_f=0x40 → pred_taken=0, pred_target=0x44, both counters 0.
- **First taken training.** Update pc=0x40, taken=1, target=0x10, pred_taken=0 → mispredict=1, redirect_pc=0x10, branch_cnt=1, mispred_cnt=1. Next cycle pc_f=0x40 → pred_taken=1, pred_target=0x10.
- **Counter hysteresis.**
  - Two more taken updates at 0x40 (correct predictions) → ctr=11, mispredict=0.
  - Then not-taken with pred_taken=1 → mispredict=1, redirect 0x44; still predicts taken (ctr=10).
  - Second not-taken → ctr=01, pred_taken=0.
- **Aliasing.** With 0x40 trained taken, pc_f=0x00 (same index, tag 0) → pred_taken=0. Non-branch update pc=0x40, pred_taken=1 → mispredict=1, redirect 0x44; next cycle 0x40 no longer hits.
- **Same-cycle access and mid-operation reset.**
  - pc_f=0x40 while updating 0x40 taken from ctr=01 → this cycle pred_taken=0, next cycle 1.
  - Reset asserted with upd_valid=1 → all tables and counters cleared, update dropped.
- **Statistics saturation.** CNT_W=4, 17 mispredicting branches → branch_cnt=mispred_cnt=4'hF, held.
